// File: rtl/cdb_writeback_arbiter.sv
// Writeback arbiter: buffers results from non-stallable FUs in per-FU FIFOs and
// drains one per cycle, round-robin, onto a registered common data bus.
module cdb_writeback_arbiter #(
  parameter  int unsigned XLEN          = 32,
  parameter  int unsigned ROB_SIZE      = 256,
  parameter  int unsigned PHYS_REG_SIZE = 256,
  parameter  int unsigned NUM_FU        = 4,
  parameter  int unsigned FIFO_DEPTH    = 4,
  parameter  int unsigned STALL_MARGIN  = 2,
  localparam int unsigned ROBW          = $clog2(ROB_SIZE),
  localparam int unsigned PRW           = $clog2(PHYS_REG_SIZE),
  localparam int unsigned SRCW          = $clog2(NUM_FU)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_FU-1:0]      fu_valid,
  input  logic [NUM_FU*XLEN-1:0] fu_result,
  input  logic [NUM_FU*ROBW-1:0] fu_rob,
  input  logic [NUM_FU*PRW-1:0]  fu_dest,
  output logic [NUM_FU-1:0]      fu_stall,
  output logic                   cdb_valid,
  output logic [XLEN-1:0]        cdb_result,
  output logic [ROBW-1:0]        cdb_rob,
  output logic [PRW-1:0]         cdb_dest,
  output logic [SRCW-1:0]        cdb_src,
  output logic                   overflow_err
);
  localparam int unsigned    PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    CW        = PW + 1;
  localparam logic [CW-1:0]  STALL_LVL = CW'(FIFO_DEPTH - STALL_MARGIN);
  localparam logic [CW-1:0]  FULL_LVL  = CW'(FIFO_DEPTH);
  localparam logic [SRCW-1:0] LAST_FU  = SRCW'(NUM_FU - 1);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [ROBW-1:0] rob;
    logic [PRW-1:0]  dest;
  } entry_t;

  entry_t          r_mem   [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]   r_wptr  [NUM_FU];
  logic [PW-1:0]   r_rptr  [NUM_FU];
  logic [CW-1:0]   r_count [NUM_FU];
  logic [SRCW-1:0] r_rr_ptr;

  entry_t            w_in [NUM_FU];
  entry_t            w_head;
  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_full;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_drop;
  logic              w_grant_vld;
  logic [SRCW-1:0]   w_grant_idx;
  logic [SRCW-1:0]   w_cand;
  logic [SRCW-1:0]   w_rr_next;

  // Per-FU input unpacking and occupancy status from registered counts.
  always_comb begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      w_in[i] = '{result: fu_result[i*XLEN +: XLEN],
                  rob:    fu_rob[i*ROBW +: ROBW],
                  dest:   fu_dest[i*PRW +: PRW]};
      w_nonempty[i] = (r_count[i] != '0);
      w_full[i]     = (r_count[i] == FULL_LVL);
      fu_stall[i]   = (r_count[i] >= STALL_LVL);
    end
  end

  // Round-robin search over non-empty FIFOs, starting at r_rr_ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      w_cand = SRCW'((32'(r_rr_ptr) + 32'(k)) % NUM_FU);
      if (!w_grant_vld && w_nonempty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_head    = r_mem[w_grant_idx][r_rptr[w_grant_idx]];
  assign w_rr_next = (w_grant_idx == LAST_FU) ? '0 : w_grant_idx + SRCW'(1);

  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      w_pop[i]  = w_grant_vld && (w_grant_idx == SRCW'(i)) && !flush;
      w_push[i] = fu_valid[i] && !flush && (!w_full[i] || w_pop[i]);
      w_drop[i] = fu_valid[i] && !flush && w_full[i] && !w_pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in[i];
    end
  end

  // FIFO pointers/counts, arbitration pointer and CDB valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_rr_ptr  <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        if (w_push[i] && !w_pop[i]) begin
          r_count[i] <= r_count[i] + CW'(1);
        end else if (!w_push[i] && w_pop[i]) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
      end
      cdb_valid <= w_grant_vld;
      if (w_grant_vld) r_rr_ptr <= w_rr_next;
    end
  end

  // CDB payload holds when nothing is granted; overflow is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_result   <= '0;
      cdb_rob      <= '0;
      cdb_dest     <= '0;
      cdb_src      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (w_drop != '0) overflow_err <= 1'b1;
      if (w_grant_vld && !flush) begin
        cdb_result <= w_head.result;
        cdb_rob    <= w_head.rob;
        cdb_dest   <= w_head.dest;
        cdb_src    <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_writeback_arbiter;
  localparam int XLEN   = 32;
  localparam int ROBW   = 8;
  localparam int PRW    = 8;
  localparam int NF     = 4;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;
  localparam int SRCW   = 2;
  localparam int EW     = XLEN + ROBW + PRW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [NF-1:0]        fu_valid;
  logic [NF*XLEN-1:0]   fu_result;
  logic [NF*ROBW-1:0]   fu_rob;
  logic [NF*PRW-1:0]    fu_dest;
  logic [NF-1:0]        fu_stall;
  logic                 cdb_valid;
  logic [XLEN-1:0]      cdb_result;
  logic [ROBW-1:0]      cdb_rob;
  logic [PRW-1:0]       cdb_dest;
  logic [SRCW-1:0]      cdb_src;
  logic                 overflow_err;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(
    .XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256),
    .NUM_FU(4), .FIFO_DEPTH(4), .STALL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_result(fu_result), .fu_rob(fu_rob), .fu_dest(fu_dest),
    .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_rob(cdb_rob), .cdb_dest(cdb_dest), .cdb_src(cdb_src),
    .overflow_err(overflow_err)
  );

  // Reference model: one queue per FU plus the expected CDB registers.
  logic [EW-1:0]   mq [NF][$];
  int              m_rr;
  logic            m_valid;
  logic [XLEN-1:0] m_res;
  logic [ROBW-1:0] m_rob;
  logic [PRW-1:0]  m_dest;
  int              m_src;
  logic            m_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int g;
    logic [EW-1:0] e;
    if (rst) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      m_rr = 0; m_valid = 1'b0; m_res = '0; m_rob = '0; m_dest = '0; m_src = 0; m_ovf = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      m_rr = 0; m_valid = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < NF; k++) begin
        if (g < 0 && mq[(m_rr + k) % NF].size() > 0) g = (m_rr + k) % NF;
      end
      if (g >= 0) begin
        e = mq[g].pop_front();
        {m_res, m_rob, m_dest} = e;
        m_valid = 1'b1;
        m_src   = g;
        m_rr    = (g + 1) % NF;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_valid[i]) begin
          if (mq[i].size() < DEPTH)
            mq[i].push_back({fu_result[i*XLEN +: XLEN], fu_rob[i*ROBW +: ROBW], fu_dest[i*PRW +: PRW]});
          else
            m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NF-1:0] exp_stall;
    for (int i = 0; i < NF; i++) exp_stall[i] = (mq[i].size() >= DEPTH - MARGIN);
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_payload", 64'({cdb_result, cdb_rob, cdb_dest, cdb_src}),
        64'({m_res, m_rob, m_dest, SRCW'(m_src)}));
    chk("fu_stall", 64'(fu_stall), 64'(exp_stall));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic clear_inputs();
    fu_valid = '0; fu_result = '0; fu_rob = '0; fu_dest = '0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic drive_fu(input int i, input logic [XLEN-1:0] r, input logic [ROBW-1:0] rb,
                          input logic [PRW-1:0] d);
    fu_valid[i]                = 1'b1;
    fu_result[i*XLEN +: XLEN]  = r;
    fu_rob[i*ROBW +: ROBW]     = rb;
    fu_dest[i*PRW +: PRW]      = d;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({cdb_valid, cdb_result, cdb_rob, cdb_dest, cdb_src, fu_stall, overflow_err}), 64'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("reset_state");
  endtask

  int prev;
  int dens;

  initial begin
    clear_inputs();

    // Single result: two-cycle latency, then idle.
    do_reset();
    drive_fu(0, 32'h1234, 8'd5, 8'd9);
    tick();
    clear_inputs();
    tick();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_data", 64'({cdb_result, cdb_rob, cdb_dest, cdb_src}), {14'd0, 32'h1234, 8'd5, 8'd9, 2'd0});
    tick();
    chk("t1_idle", 64'(cdb_valid), 64'd0);

    // All four FUs in one cycle drain in index order.
    do_reset();
    for (int i = 0; i < NF; i++) drive_fu(i, 32'hA000 + 32'(i), 8'(i + 1), 8'(i + 10));
    tick();
    clear_inputs();
    for (int i = 0; i < NF; i++) begin
      tick();
      chk("t2_valid", 64'(cdb_valid), 64'd1);
      chk("t2_src", 64'(cdb_src), 64'(i));
      chk("t2_result", 64'(cdb_result), 64'(32'hA000 + 32'(i)));
    end
    tick();
    chk("t2_idle", 64'(cdb_valid), 64'd0);

    // FU1 and FU3 every cycle: grants alternate.
    do_reset();
    prev = -1;
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      if (c < 10) begin
        drive_fu(1, $urandom, 8'($urandom), 8'($urandom));
        drive_fu(3, $urandom, 8'($urandom), 8'($urandom));
      end
      tick();
      if (c >= 1 && c <= 12) begin
        chk("t3_valid", 64'(cdb_valid), 64'd1);
        chk("t3_alternate", 64'(cdb_src), 64'((prev == 1) ? 3 : 1));
        prev = int'(cdb_src);
      end
    end

    // Saturating traffic: stalls, overflow, sticky after drain.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      for (int i = 0; i < NF; i++) drive_fu(i, $urandom, 8'($urandom), 8'($urandom));
      tick();
      if (c == 1) chk("t4_stall_rise", 64'(fu_stall), 64'(4'b1110));
    end
    chk("t4_stall_all", 64'(fu_stall), 64'(4'hF));
    chk("t4_overflow", 64'(overflow_err), 64'd1);
    clear_inputs();
    for (int c = 0; c < 20; c++) tick();
    chk("t4_drained", 64'({cdb_valid, fu_stall}), 64'd0);
    chk("t4_sticky", 64'(overflow_err), 64'd1);

    // Flush drops FU2 contents; a later push still takes two cycles.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      drive_fu(2, $urandom, 8'($urandom), 8'($urandom));
      tick();
    end
    clear_inputs();
    flush = 1'b1;
    drive_fu(0, 32'hDEAD, 8'd1, 8'd1);
    tick();
    clear_inputs();
    chk("t5_flush", 64'({cdb_valid, fu_stall}), 64'd0);
    tick();
    chk("t5_discard", 64'(cdb_valid), 64'd0);
    drive_fu(2, 32'hBEEF, 8'd7, 8'd3);
    tick();
    clear_inputs();
    chk("t5_latency_early", 64'(cdb_valid), 64'd0);
    tick();
    chk("t5_after", 64'({cdb_valid, cdb_result, cdb_src}), 64'({1'b1, 32'hBEEF, 2'd2}));

    // Reset mid-traffic: everything zero, nothing stale later.
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      for (int i = 0; i < NF; i++) drive_fu(i, $urandom, 8'($urandom), 8'($urandom));
      tick();
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t6_no_stale", 64'(cdb_valid), 64'd0);
    end

    // Randomized traffic with occasional flush and reset.
    dens = 2;
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if (c % 200 == 0) dens = int'($urandom_range(0, 4));
      for (int i = 0; i < NF; i++) begin
        if (int'($urandom_range(0, 3)) < dens) drive_fu(i, $urandom, 8'($urandom), 8'($urandom));
      end
      if ($urandom_range(0, 63) == 0) flush = 1'b1;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
